// File: rtl/waitstate_gen.sv
// Wait-state generator for the data bus driver.
// Each bus cycle (memory or I/O strobe) holds the active-low wait request nws
// for a programmed number of clk2 cycles. It then extends the cycle while the
// device pulls nwaitreq low. If the device holds nwaitreq low for too long,
// the cycle aborts with a bus error on nbuserr.
module waitstate_gen #(
  parameter int unsigned MEM_WS     = 0,        // fast memory wait states (0..15)
  parameter int unsigned SLOW_WS    = 3,        // slow-page memory wait states (0..15)
  parameter int unsigned IO_WS      = 2,        // I/O wait states (0..15)
  parameter logic [15:0] SLOW_PAGES = 16'h8000, // bit p set: memory page p is slow
  parameter int unsigned TIMEOUT    = 64        // max clk2 cycles in external wait (1..255)
) (
  input  logic       clk2,
  input  logic       nreset,
  input  logic       nmem,
  input  logic       nio,
  input  logic [3:0] ab_page,
  input  logic       nwaitreq,
  output logic       nws,
  output logic       nbuserr,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    EXTWAIT,
    DONE,
    ERROR
  } state_e;

  localparam logic [3:0] MEM_WS_L   = 4'(MEM_WS);
  localparam logic [3:0] SLOW_WS_L  = 4'(SLOW_WS);
  localparam logic [3:0] IO_WS_L    = 4'(IO_WS);
  localparam logic [7:0] TLAST      = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] tcnt_q;
  logic       s_prev_q;
  logic       s_prev_d;
  logic       nws_q;
  logic       nbuserr_q;
  logic       busy_q;

  logic       start;
  logic [3:0] ws_n;

  // A cycle is active while either strobe is low. It starts on the first
  // edge that sees a strobe after an edge with none. A strobe held low
  // continuously therefore never restarts the count.
  assign s_prev_d = ~(nmem & nio);
  assign start    = s_prev_d & ~s_prev_q;

  // Wait-state count for the cycle being started. I/O takes precedence, so
  // the illegal both-low case never uses this value.
  assign ws_n = !nio                          ? IO_WS_L   :
                (!nmem && SLOW_PAGES[ab_page]) ? SLOW_WS_L : MEM_WS_L;

  // Cycle FSM with registered nws/nbuserr/busy. Cycle end overrides every state.
  // NOTE: all state here uses non-blocking assignments, so each register
  // samples values from before the edge and update order inside the block
  // does not matter.
  always_ff @(posedge clk2 or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      s_prev_q  <= 1'b0;
      nws_q     <= 1'b1;
      nbuserr_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      s_prev_q <= s_prev_d;
      if (!s_prev_d) begin
        state_q   <= IDLE;
        nws_q     <= 1'b1;
        nbuserr_q <= 1'b1;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              busy_q <= 1'b1;
              if (!nmem && !nio) begin
                state_q   <= ERROR;
                nws_q     <= 1'b1;
                nbuserr_q <= 1'b0;
              end else if (ws_n != 4'd0) begin
                state_q <= COUNT;
                cnt_q   <= ws_n - 4'd1;
                nws_q   <= 1'b0;
              end else if (!nwaitreq) begin
                state_q <= EXTWAIT;
                tcnt_q  <= '0;
                nws_q   <= 1'b0;
              end else begin
                state_q <= DONE;
                nws_q   <= 1'b1;
              end
            end
          end
          COUNT: begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else if (nwaitreq) begin
              state_q <= DONE;
              nws_q   <= 1'b1;
            end else begin
              state_q <= EXTWAIT;
              tcnt_q  <= '0;
            end
          end
          EXTWAIT: begin
            if (nwaitreq) begin
              state_q <= DONE;
              nws_q   <= 1'b1;
            end else if (tcnt_q == TLAST) begin
              state_q   <= ERROR;
              nws_q     <= 1'b1;
              nbuserr_q <= 1'b0;
            end else begin
              tcnt_q <= tcnt_q + 8'd1;
            end
          end
          DONE, ERROR: begin
            // Held until both strobes return high.
          end
          default: begin
            state_q   <= IDLE;
            nws_q     <= 1'b1;
            nbuserr_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign nws     = nws_q;
  assign nbuserr = nbuserr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_waitstate_gen.sv
// Directed bench for waitstate_gen. Stimulus pushes the expected
// {nws, nbuserr, busy} for each clk2 edge into a scoreboard queue. A monitor
// pops one entry on every falling edge and compares it with the DUT outputs.
module tb_waitstate_gen;

  localparam int IO_WS   = 2;
  localparam int SLOW_WS = 3;
  localparam int TIMEOUT = 64;

  logic       clk2;
  logic       nreset;
  logic       nmem;
  logic       nio;
  logic [3:0] ab_page;
  logic       nwaitreq;
  logic       nws;
  logic       nbuserr;
  logic       busy;

  typedef struct {
    string      name;
    logic [2:0] exp;   // {nws, nbuserr, busy}
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  waitstate_gen #(
    .MEM_WS    (0),
    .SLOW_WS   (SLOW_WS),
    .IO_WS     (IO_WS),
    .SLOW_PAGES(16'h8000),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk2    (clk2),
    .nreset  (nreset),
    .nmem    (nmem),
    .nio     (nio),
    .ab_page (ab_page),
    .nwaitreq(nwaitreq),
    .nws     (nws),
    .nbuserr (nbuserr),
    .busy    (busy)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: nws/nbuserr/busy got %b required %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input string nm, input logic e_nws, input logic e_be, input logic e_busy);
    exp_t e;
    e.name = nm;
    e.exp  = {e_nws, e_be, e_busy};
    sb.push_back(e);
  endtask

  // Drive one set of inputs and record the outputs expected after the next edge.
  task automatic cyc(input logic m, input logic io, input logic [3:0] pg, input logic wr,
                     input logic e_nws, input logic e_be, input logic e_busy, input string nm);
    nmem     = m;
    nio      = io;
    ab_page  = pg;
    nwaitreq = wr;
    @(posedge clk2);
    #1 push(nm, e_nws, e_be, e_busy);
  endtask

  // Monitor: compare one scoreboard entry per falling edge.
  initial begin
    forever begin
      @(negedge clk2);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, {nws, nbuserr, busy}, e.exp);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; nmem = 1'b1; nio = 1'b1; ab_page = 4'h0; nwaitreq = 1'b1;
    #1 push("reset", 1'b1, 1'b1, 1'b0);
    @(negedge clk2);
    #1 nreset = 1'b1;
    cyc(1, 1, 4'h0, 1, 1, 1, 0, "idle0");

    // Fast memory, zero wait states: nws never drops, busy spans the cycle.
    cyc(0, 1, 4'h2, 1, 1, 1, 1, "mem0_start");
    cyc(0, 1, 4'h2, 1, 1, 1, 1, "mem0_hold");
    cyc(0, 1, 4'h2, 1, 1, 1, 1, "mem0_hold");
    cyc(1, 1, 4'h2, 1, 1, 1, 0, "mem0_end");

    // I/O with two wait states.
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 4'h0, 1, (i < IO_WS) ? 1'b0 : 1'b1, 1, 1, "io2");
    cyc(1, 1, 4'h0, 1, 1, 1, 0, "io2_end");

    // Slow page: 3 counted states, then 5 edges of external wait.
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 4'hF, (i >= 3 && i < 8) ? 1'b0 : 1'b1,
          (i < 8) ? 1'b0 : 1'b1, 1, 1, "slow_ext");
    cyc(1, 1, 4'hF, 1, 1, 1, 0, "slow_ext_end");

    // I/O with nwaitreq stuck low: timeout after IO_WS + TIMEOUT edges.
    for (int i = 0; i < 70; i++)
      cyc(1, 0, 4'h0, 0, (i < 66) ? 1'b0 : 1'b1, (i < 66) ? 1'b1 : 1'b0, 1, "timeout");
    cyc(1, 1, 4'h0, 0, 1, 1, 0, "timeout_end");
    cyc(1, 1, 4'h0, 1, 1, 1, 0, "idle1");

    // Both strobes low: illegal, immediate bus error.
    cyc(0, 0, 4'h0, 1, 1, 0, 1, "both_low");
    cyc(0, 0, 4'h0, 1, 1, 0, 1, "both_low_hold");
    cyc(1, 1, 4'h0, 1, 1, 1, 0, "both_low_end");

    // Slow cycle aborted mid-count by nmem rising.
    cyc(0, 1, 4'hF, 1, 0, 1, 1, "abort_start");
    cyc(1, 1, 4'hF, 1, 1, 1, 0, "abort_end");

    // Back-to-back: one idle edge between cycles allows a fresh start.
    cyc(1, 0, 4'h0, 1, 0, 1, 1, "b2b_io");
    cyc(1, 0, 4'h0, 1, 0, 1, 1, "b2b_io");
    cyc(1, 0, 4'h0, 1, 1, 1, 1, "b2b_io");
    cyc(1, 1, 4'h0, 1, 1, 1, 0, "b2b_gap");
    cyc(0, 1, 4'hF, 1, 0, 1, 1, "b2b_slow");

    // Asynchronous reset mid-COUNT, sampled before any further clock edge.
    @(posedge clk2);
    #2 nreset = 1'b0;
    push("rst_async", 1'b1, 1'b1, 1'b0);
    nmem = 1'b1;
    @(negedge clk2);
    #1 nreset = 1'b1;
    cyc(1, 1, 4'h0, 1, 1, 1, 0, "post_reset");

    @(negedge clk2);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
